// File: rtl/raster_block_splitter.sv
// raster_block_splitter
//   Turns a raster pixel stream (8 adjacent pixels per beat, line after line)
//   into 8x8 blocks, emitted as 8 consecutive row beats per block. One 8-line
//   stripe is held per bank of a two-bank ping-pong store, so the next stripe
//   can be written while the previous one is read out.
//
// Ports
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_valid   : input beat valid
//   in_ready   : beat accepted when in_valid && in_ready
//   in_data    : in_data[k] = pixel x = 8*col+k of the current line
//   in_sof     : first beat of a frame; restarts the current stripe
//   out_valid  : output row beat valid
//   out_data   : out_data[k] = pixel column k of the current block row
//   out_sob    : row 0 of a block
//   out_eob    : row 7 of a block
//   out_sof    : row 0 of block 0 of a stripe that began with in_sof
module raster_block_splitter #(
    parameter int W_IO  = 8,
    parameter int IMG_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0][W_IO-1:0] in_data,
    input  logic                 in_sof,
    output logic                 out_valid,
    output logic [7:0][W_IO-1:0] out_data,
    output logic                 out_sob,
    output logic                 out_eob,
    output logic                 out_sof
);

    localparam int BPR   = IMG_W / 8;
    localparam int DEPTH = 8 * BPR;
    localparam int AW    = $clog2(2 * DEPTH);
    localparam int CW    = (BPR > 1) ? $clog2(BPR) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(BPR - 1);

    typedef enum logic {IDLE, READ} rd_state_t;

    // Flat word address: bank selects the upper half of the store.
    function automatic logic [AW-1:0] addr_of(input logic bank,
                                              input logic [2:0] line,
                                              input logic [CW-1:0] col);
        int a;
        a = (bank ? DEPTH : 0) + int'(line) * BPR + int'(col);
        return AW'(a);
    endfunction

    logic [7:0][W_IO-1:0] mem [2*DEPTH];

    // Writer state
    logic            run;
    logic            wr_bank;
    logic [CW-1:0]   wr_col;
    logic [2:0]      wr_line;
    logic [1:0]      full;
    logic [1:0]      sof_flag;
    logic            accept;
    logic [CW-1:0]   eff_col;
    logic [2:0]      eff_line;
    logic            wr_last;
    logic [AW-1:0]   wr_addr;
    logic [1:0]      set_full;

    // Reader state
    rd_state_t       state;
    logic            rd_bank;
    logic            nxt_bank;
    logic [CW-1:0]   rd_blk;
    logic [2:0]      rd_row;
    logic            start_bank;
    logic            cur_bank;
    logic            rd_issue;
    logic            rd_last;
    logic [AW-1:0]   rd_addr;
    logic [1:0]      clr_full;

    // Read pipeline
    logic [7:0][W_IO-1:0] rd_data_p0;
    logic            vld_p0;
    logic            sob_p0;
    logic            eob_p0;
    logic            sof_p0;

    // run holds in_ready low until the first clock after reset release.
    assign in_ready = run && !full[wr_bank];
    assign accept   = in_valid && in_ready;

    // in_sof restarts the stripe at (0,0), dropping any partial lines.
    always_comb begin
        eff_col  = in_sof ? '0 : wr_col;
        eff_line = in_sof ? '0 : wr_line;
        wr_last  = (eff_line == 3'd7) && (eff_col == COL_LAST);
        wr_addr  = addr_of(wr_bank, eff_line, eff_col);
        set_full = (accept && wr_last) ? (2'b01 << wr_bank) : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run      <= 1'b0;
            wr_bank  <= 1'b0;
            wr_col   <= '0;
            wr_line  <= '0;
            full     <= 2'b00;
            sof_flag <= 2'b00;
        end else begin
            run  <= 1'b1;
            // The reader only clears the bank it reads and the writer only
            // fills a bank that is empty, so set and clear never collide.
            full <= (full & ~clr_full) | set_full;
            if (accept) begin
                if (eff_line == 3'd0 && eff_col == '0)
                    sof_flag[wr_bank] <= in_sof;
                if (eff_col == COL_LAST) begin
                    wr_col  <= '0;
                    wr_line <= eff_line + 3'd1;
                end else begin
                    wr_col  <= eff_col + 1'b1;
                    wr_line <= eff_line;
                end
                if (wr_last)
                    wr_bank <= !wr_bank;
            end
        end
    end

    // From IDLE the first read issues in the same cycle a bank is seen full,
    // which keeps the fill-to-output latency at two clocks.
    always_comb begin
        start_bank = full[nxt_bank] ? nxt_bank : !nxt_bank;
        cur_bank   = (state == READ) ? rd_bank : start_bank;
        rd_issue   = (state == READ) || (full != 2'b00);
        rd_last    = (rd_row == 3'd7) && (rd_blk == COL_LAST);
        rd_addr    = addr_of(cur_bank, rd_row, rd_blk);
        clr_full   = (rd_issue && rd_last) ? (2'b01 << cur_bank) : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_bank  <= 1'b0;
            nxt_bank <= 1'b0;
            rd_blk   <= '0;
            rd_row   <= '0;
            vld_p0   <= 1'b0;
            sob_p0   <= 1'b0;
            eob_p0   <= 1'b0;
            sof_p0   <= 1'b0;
        end else begin
            vld_p0 <= rd_issue;
            sob_p0 <= rd_issue && (rd_row == 3'd0);
            eob_p0 <= rd_issue && (rd_row == 3'd7);
            sof_p0 <= rd_issue && (rd_row == 3'd0) && (rd_blk == '0)
                      && sof_flag[cur_bank];
            if (rd_issue) begin
                if (rd_last) begin
                    rd_row   <= '0;
                    rd_blk   <= '0;
                    nxt_bank <= !cur_bank;
                    rd_bank  <= !cur_bank;
                    state    <= full[!cur_bank] ? READ : IDLE;
                end else begin
                    rd_bank <= cur_bank;
                    state   <= READ;
                    if (rd_row == 3'd7) begin
                        rd_row <= '0;
                        rd_blk <= rd_blk + 1'b1;
                    end else begin
                        rd_row <= rd_row + 3'd1;
                    end
                end
            end
        end
    end

    // Stage p0: store write port and registered read port
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_addr] <= in_data;
        if (rd_issue)
            rd_data_p0 <= mem[rd_addr];
    end

    // Stage p1: output register; data holds while no row is valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_sof   <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= vld_p0;
            out_sob   <= sob_p0;
            out_eob   <= eob_p0;
            out_sof   <= sof_p0;
            if (vld_p0)
                out_data <= rd_data_p0;
        end
    end

endmodule

// File: tb/tb_raster_block_splitter.sv
// Testbench for raster_block_splitter (IMG_W=16, two blocks per stripe).
// A stripe-level reference model collects 16 accepted beats, then schedules
// the 16 block rows two clocks after the completing beat (or right after the
// previous stripe's last row) and compares every output cycle.
module tb_raster_block_splitter;

    localparam int W_IO   = 8;
    localparam int IMG_W  = 16;
    localparam int BPR    = IMG_W / 8;
    localparam int SBEATS = 8 * BPR;

    typedef logic [7:0][W_IO-1:0] pix_t;
    typedef struct {
        int   cyc;
        pix_t data;
        bit   sob;
        bit   eob;
        bit   sof;
    } row_t;
    typedef struct {
        int done;
        int last;
    } stripe_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    pix_t in_data = '0;
    logic in_sof = 1'b0;
    logic out_valid;
    pix_t out_data;
    logic out_sob;
    logic out_eob;
    logic out_sof;

    always #5 clk = ~clk;

    raster_block_splitter #(.W_IO(W_IO), .IMG_W(IMG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .out_valid(out_valid), .out_data(out_data),
        .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof)
    );

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    bit      run_m = 0;
    pix_t    sbuf [SBEATS];
    int      pos = 0;
    bit      ssof = 0;
    int      last_sched = -1000;
    pix_t    last_out = '0;
    row_t    expq [$];
    stripe_t stq [$];

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input pix_t obs, input pix_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic pix_t rand_pix();
        pix_t p;
        for (int k = 0; k < 8; k++) p[k] = W_IO'($urandom);
        return p;
    endfunction

    function automatic pix_t ramp_pix(input int beat);
        pix_t p;
        int y, c;
        y = beat / BPR;
        c = beat % BPR;
        for (int k = 0; k < 8; k++) p[k] = W_IO'(y * IMG_W + 8 * c + k);
        return p;
    endfunction

    // Ready unless two finished stripes are still waiting to be drained; a
    // stripe's bank frees one clock before its last row appears.
    function automatic bit model_ready();
        int n = 0;
        foreach (stq[i])
            if (stq[i].done <= cyc && stq[i].last - 1 > cyc) n++;
        return run_m && (n < 2);
    endfunction

    task automatic model_accept(input pix_t d, input bit s);
        if (s) pos = 0;
        if (pos == 0) ssof = s;
        sbuf[pos] = d;
        pos++;
        if (pos == SBEATS) begin
            int first;
            first = (cyc + 2 > last_sched + 1) ? cyc + 2 : last_sched + 1;
            for (int blk = 0; blk < BPR; blk++) begin
                for (int r = 0; r < 8; r++) begin
                    row_t e;
                    e.cyc  = first + blk * 8 + r;
                    // block blk, row r = line r's beat covering pixels 8*blk..8*blk+7
                    e.data = sbuf[r * BPR + blk];
                    e.sob  = (r == 0);
                    e.eob  = (r == 7);
                    e.sof  = ssof && (r == 0) && (blk == 0);
                    expq.push_back(e);
                end
            end
            last_sched = first + SBEATS - 1;
            stq.push_back('{cyc, last_sched});
            pos = 0;
        end
    endtask

    task automatic check_outputs();
        bit exp_v;
        exp_v = (expq.size() > 0) && (expq[0].cyc == cyc);
        chk_bit("out_valid", out_valid, exp_v);
        if (exp_v) begin
            row_t e;
            e = expq.pop_front();
            chk_pix("out_data", out_data, e.data);
            chk_bit("out_sob", out_sob, e.sob);
            chk_bit("out_eob", out_eob, e.eob);
            chk_bit("out_sof", out_sof, e.sof);
            last_out = e.data;
        end else begin
            chk_pix("out_data_hold", out_data, last_out);
        end
        while (expq.size() > 0 && expq[0].cyc <= cyc) void'(expq.pop_front());
    endtask

    task automatic tick();
        bit acc;
        chk_bit("in_ready", in_ready, model_ready());
        acc = in_valid && model_ready();
        @(posedge clk);
        #1;
        cyc++;
        run_m = 1;
        if (acc) model_accept(in_data, in_sof);
        check_outputs();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_beat(input pix_t d, input bit s);
        int tries = 0;
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        do begin
            acc = model_ready();
            tick();
            tries++;
        end while (!acc && tries < 100);
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL beat_accept: observed not accepted after %0d cycles expected accepted", tries);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst = 1'b1;
        #1;
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_out_sob", out_sob, 1'b0);
        chk_bit("rst_out_eob", out_eob, 1'b0);
        chk_bit("rst_out_sof", out_sof, 1'b0);
        chk_pix("rst_out_data", out_data, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_m = 0;
        expq.delete();
        stq.delete();
        pos = 0;
        ssof = 0;
        last_sched = -1000;
        last_out = '0;
    endtask

    initial begin
        // Ramp image stripe, pixel(x,y) = y*16+x
        @(posedge clk);
        #1;
        do_reset();
        for (int b = 0; b < SBEATS; b++) send_beat(ramp_pix(b), b == 0);
        idle(24);

        // Two stripes back to back, sof only on the first
        for (int b = 0; b < 2 * SBEATS; b++) send_beat(rand_pix(), b == 0);
        idle(40);

        // Reset after 5 beats of a stripe, then a fresh stripe
        for (int b = 0; b < 5; b++) send_beat(rand_pix(), b == 0);
        do_reset();
        for (int b = 0; b < SBEATS; b++) send_beat(rand_pix(), b == 0);
        idle(24);

        // Resynchronise with in_sof on beat 6
        for (int b = 0; b < 5; b++) send_beat(rand_pix(), b == 0);
        for (int b = 0; b < SBEATS; b++) send_beat(rand_pix(), b == 0);
        idle(24);

        // Four stripes with random idle gaps between beats
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < SBEATS; b++) begin
                idle($urandom_range(0, 36));
                send_beat(rand_pix(), (s == 0) && (b == 0));
            end
        end
        idle(40);
        chk_int("rows_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
